// File: rtl/ft245_fifo_bridge.sv
// FT245-style parallel FIFO bridge: strobe-timing FSM between the synchronized pins
// and two first-word-fall-through byte FIFOs exposed to the SoC as valid/ready streams.

module ft245_fwft_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic [7:0]                     wdata,
  input  logic                           pop,
  output logic [7:0]                     rdata,
  output logic [$clog2(DEPTH+1)-1:0]     count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  // Pointers wrap naturally because DEPTH is a power of two; occupancy is tracked separately.
  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

module ft245_fifo_bridge #(
  parameter int RX_DEPTH = 16,
  parameter int TX_DEPTH = 16,
  parameter int RD_PULSE = 4,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 3,
  parameter int RECOVER  = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [7:0]                      uart_rdata,
  output logic [7:0]                      uart_wdata,
  output logic                            uart_oe,
  input  logic                            uart_rxf,
  input  logic                            uart_txe,
  output logic                            uart_rd,
  output logic                            uart_wr,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  input  logic [7:0]                      tx_data,
  input  logic                            tx_valid,
  output logic                            tx_ready,
  output logic [$clog2(RX_DEPTH+1)-1:0]   rx_count,
  output logic [$clog2(TX_DEPTH+1)-1:0]   tx_count
);
  localparam int RCW = $clog2(RX_DEPTH + 1);
  localparam int TCW = $clog2(TX_DEPTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_RECOVER
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       prefer_rx_q, prefer_rx_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_ok, wr_ok;
  logic       rx_push, tx_pop;
  logic       rx_pop, tx_push;
  logic [7:0] tx_head;

  assign rx_pop  = rx_valid && rx_ready;
  assign tx_push = tx_valid && tx_ready;

  ft245_fwft_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .wdata (uart_rdata),
    .pop   (rx_pop),
    .rdata (rx_data),
    .count (rx_count)
  );

  ft245_fwft_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .wdata (tx_data),
    .pop   (tx_pop),
    .rdata (tx_head),
    .count (tx_count)
  );

  assign rx_valid = (rx_count != '0);
  assign tx_ready = (tx_count < TCW'(TX_DEPTH));

  // RX space is reserved at the IDLE decision: the SoC can only drain it afterwards.
  assign rd_ok = !uart_rxf && (rx_count < RCW'(RX_DEPTH));
  assign wr_ok = !uart_txe && (tx_count != '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prefer_rx_d = prefer_rx_q;
    wdata_d     = wdata_q;
    rx_push     = 1'b0;
    tx_pop      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (rd_ok && (!wr_ok || prefer_rx_q)) begin
          state_d     = ST_RD_STROBE;
          cnt_d       = '0;
          prefer_rx_d = 1'b0;
        end else if (wr_ok) begin
          state_d     = ST_WR_SETUP;
          cnt_d       = '0;
          prefer_rx_d = 1'b1;
          tx_pop      = 1'b1;
          wdata_d     = tx_head;
        end
      end
      ST_RD_STROBE: begin
        if (cnt_q == 8'(RD_PULSE - 1)) begin
          rx_push = 1'b1;
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WR_SETUP: begin
        if (cnt_q == 8'(WR_SETUP - 1)) begin
          state_d = ST_WR_STROBE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WR_STROBE: begin
        if (cnt_q == 8'(WR_PULSE - 1)) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RECOVER: begin
        // Lets the synchronized RXF#/TXE# catch up before the next IDLE decision.
        if (cnt_q == 8'(RECOVER - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prefer_rx_q <= 1'b1;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prefer_rx_q <= prefer_rx_d;
      wdata_q     <= wdata_d;
    end
  end

  // Strobes decode straight from registered state, so RD and WR/OE are mutually exclusive.
  assign uart_rd    = (state_q == ST_RD_STROBE);
  assign uart_wr    = (state_q == ST_WR_STROBE);
  assign uart_oe    = (state_q == ST_WR_SETUP) || (state_q == ST_WR_STROBE);
  assign uart_wdata = wdata_q;
endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Directed bench for ft245_fifo_bridge: strobe timing, FIFO boundaries, arbitration and reset.

module tb_ft245_fifo_bridge;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] uart_rdata, uart_wdata;
  logic       uart_oe, uart_rxf, uart_txe, uart_rd, uart_wr;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [4:0] rx_count, tx_count;

  int checks = 0;
  int errors = 0;
  int hi, lo, n, rises, overlap, nstarts;
  logic prev_rd, prev_oe;
  logic [5:0] seq;
  logic [7:0] exp_b;
  logic [7:0] wexp [3];

  always #5 clk = ~clk;

  ft245_fifo_bridge dut (
    .clk        (clk),
    .reset      (reset),
    .uart_rdata (uart_rdata),
    .uart_wdata (uart_wdata),
    .uart_oe    (uart_oe),
    .uart_rxf   (uart_rxf),
    .uart_txe   (uart_txe),
    .uart_rd    (uart_rd),
    .uart_wr    (uart_wr),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rx_count   (rx_count),
    .tx_count   (tx_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rd(input string tag);
    int k = 0;
    while (uart_rd !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk(tag, uart_rd, 1);
  endtask

  task automatic wait_oe(input string tag);
    int k = 0;
    while (uart_oe !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk(tag, uart_oe, 1);
  endtask

  task automatic wait_wr(input string tag);
    int k = 0;
    while (uart_wr !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    chk(tag, uart_wr, 1);
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_rd"}, uart_rd, 0);
    chk({tag, "_wr"}, uart_wr, 0);
    chk({tag, "_oe"}, uart_oe, 0);
    chk({tag, "_wdata"}, uart_wdata, 0);
    chk({tag, "_rx_valid"}, rx_valid, 0);
    chk({tag, "_tx_ready"}, tx_ready, 1);
    chk({tag, "_rx_count"}, rx_count, 0);
    chk({tag, "_tx_count"}, tx_count, 0);
  endtask

  initial begin
    wexp[0] = 8'h11; wexp[1] = 8'h22; wexp[2] = 8'h33;
    reset = 1'b1; uart_rdata = 8'hA5; uart_rxf = 1'b0; uart_txe = 1'b1;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset_state("reset");
    reset = 1'b0;

    // Reads fill RX: first read timing, then 15 more with distinct bytes.
    for (int k = 0; k < 16; k++) begin
      wait_rd("rd_start");
      if (k == 0) chk("rx_valid_during_strobe", rx_valid, 0);
      uart_rdata = (k == 0) ? 8'hA5 : 8'(8'h80 + k);
      hi = 0;
      while (uart_rd && hi < 10) begin
        if (uart_wr || uart_oe) errors++;
        hi++; @(negedge clk);
      end
      if (k == 0) begin
        chk("rd_pulse_width", hi, 4);
        chk("rx_valid_after_strobe", rx_valid, 1);
        chk("rx_data_first", rx_data, 8'hA5);
        lo = 0;
        while (!uart_rd && lo < 20) begin lo++; @(negedge clk); end
        chk("rd_gap", lo, 4);
      end
    end
    chk("rx_full_count", rx_count, 16);
    rises = 0;
    repeat (30) begin
      if (uart_rd) rises++;
      @(negedge clk);
    end
    chk("no_rd_when_full", rises, 0);
    chk("rx_head_held", rx_data, 8'hA5);

    uart_rdata = 8'hC3;
    rx_ready = 1'b1; @(negedge clk); rx_ready = 1'b0;
    chk("rx_pop_one", rx_count, 15);
    rises = 0; prev_rd = uart_rd;
    repeat (40) begin
      @(negedge clk);
      if (uart_rd && !prev_rd) rises++;
      prev_rd = uart_rd;
    end
    chk("one_more_read", rises, 1);
    chk("rx_refull", rx_count, 16);

    uart_rxf = 1'b1;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_b = (i < 15) ? 8'(8'h81 + i) : 8'hC3;
      chk("rx_drain_order", rx_data, exp_b);
      @(negedge clk);
    end
    rx_ready = 1'b0;
    chk("rx_empty_valid", rx_valid, 0);
    chk("rx_empty_count", rx_count, 0);

    // Three writes: OE leads WR by one cycle, WR three cycles, data held after.
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = wexp[i]; @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("tx_count_3", tx_count, 3);
    uart_txe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_oe("oe_rise");
      chk("wr_low_in_setup", uart_wr, 0);
      chk("wdata_value", uart_wdata, wexp[k]);
      @(negedge clk);
      hi = 0; lo = 0;
      while (uart_wr && hi < 10) begin
        if (!uart_oe || uart_rd) lo++;
        hi++; @(negedge clk);
      end
      chk("wr_pulse_width", hi, 3);
      chk("oe_during_wr", lo, 0);
      chk("oe_drops_with_wr", uart_oe, 0);
      chk("wdata_hold", uart_wdata, wexp[k]);
    end
    chk("tx_drained", tx_count, 0);

    // Both sides ready: strict RD/WR alternation, no overlap.
    uart_txe = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h40 + i); @(negedge clk);
    end
    tx_valid = 1'b0;
    rx_ready = 1'b1;
    uart_rxf = 1'b0; uart_txe = 1'b0;
    seq = '0; nstarts = 0; overlap = 0; prev_rd = 1'b0; prev_oe = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (uart_rd && (uart_wr || uart_oe)) overlap++;
      if (nstarts < 6 && uart_rd && !prev_rd) begin seq = {seq[4:0], 1'b0}; nstarts++; end
      if (nstarts < 6 && uart_oe && !prev_oe) begin seq = {seq[4:0], 1'b1}; nstarts++; end
      prev_rd = uart_rd; prev_oe = uart_oe;
    end
    chk("alt_starts", nstarts, 6);
    chk("alt_sequence", seq, 6'b010101);
    chk("alt_overlap", overlap, 0);
    uart_rxf = 1'b1; uart_txe = 1'b1;
    repeat (20) @(negedge clk);
    rx_ready = 1'b0;
    chk("alt_tx_empty", tx_count, 0);
    chk("alt_rx_empty", rx_count, 0);

    // TX fill to full, blocked push, simultaneous push/pop at 8.
    for (int i = 0; i < 16; i++) begin
      tx_valid = 1'b1; tx_data = 8'(8'h20 + i); @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("tx_full_count", tx_count, 16);
    chk("tx_full_ready", tx_ready, 0);
    tx_valid = 1'b1; tx_data = 8'hFF; @(negedge clk); tx_valid = 1'b0;
    chk("tx_push_while_full", tx_count, 16);
    uart_txe = 1'b0;
    n = 0;
    while (tx_count != 5'd8 && n < 120) begin @(negedge clk); n++; end
    uart_txe = 1'b1;
    chk("tx_reach_8", tx_count, 8);
    repeat (12) @(negedge clk);
    uart_txe = 1'b0; tx_valid = 1'b1; tx_data = 8'hAA;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("tx_push_pop_count", tx_count, 8);
    chk("tx_push_pop_oe", uart_oe, 1);
    chk("tx_push_pop_wdata", uart_wdata, 8'h28);

    // Reset during cycle 2 of the WR strobe.
    wait_wr("wr_before_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset_state("reset_mid_wr");
    uart_txe = 1'b1; uart_rxf = 1'b0; reset = 1'b0;

    // Reset during cycle 2 of an RD strobe: byte must not reach RX.
    wait_rd("rd_before_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid_rd_rd", uart_rd, 0);
    chk("reset_mid_rd_count", rx_count, 0);
    uart_rxf = 1'b1; reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("no_rx_push_after_reset", rx_valid, 0);
    chk("idle_after_reset", uart_rd | uart_wr | uart_oe, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
